// File: rtl/gf180mcu_ocd_io_in_ctrl.sv
// Input pad bank controller: registered pull decode, 2-flop Y sync, per-pad debounce, floating-pad pull-scan.
// Latency: pulls 1 cycle, y_sync 2 cycles, y_deb y_sync + threshold; no backpressure, scan_start ignored while busy.
module gf180mcu_ocd_io_in_ctrl #(
  parameter int NPAD   = 8,
  parameter int SETTLE = 6,
  parameter int DEBW   = 4
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic [NPAD-1:0] cfg_pu,
  input  logic [NPAD-1:0] cfg_pd,
  input  logic [DEBW-1:0] deb_thresh,
  input  logic            scan_start,
  input  logic [NPAD-1:0] pad_y,
  output logic [NPAD-1:0] pad_pu,
  output logic [NPAD-1:0] pad_pd,
  output logic [NPAD-1:0] y_sync,
  output logic [NPAD-1:0] y_deb,
  output logic            scan_busy,
  output logic            scan_done,
  output logic [NPAD-1:0] float_flag
);

  localparam int IW = (NPAD > 1) ? $clog2(NPAD) : 1;
  localparam int WW = $clog2(SETTLE);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NPAD - 1);
  localparam logic [WW-1:0] WCNT_LAST = WW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, TEST_UP, TEST_DN, DONE} state_t;

  state_t                     state_q;
  logic [IW-1:0]              idx_q;
  logic [WW-1:0]              wcnt_q;
  logic                       hi_q;
  logic [NPAD-1:0]            flt_q;

  logic [NPAD-1:0]            sync1_q, sync2_q;
  logic [NPAD-1:0]            pu_q, pu_d, pd_q, pd_d;
  logic [NPAD-1:0]            deb_q, deb_d;
  logic [NPAD-1:0][DEBW-1:0]  cnt_q, cnt_d;
  logic [DEBW-1:0]            thr;
  logic                       busy;

  assign busy = (state_q != IDLE);
  assign thr  = (deb_thresh == '0) ? DEBW'(1) : deb_thresh;

  // Scan sequencer: each pad sees SETTLE cycles of pull-up, then SETTLE of pull-down.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      hi_q    <= 1'b0;
      flt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (scan_start) begin
            state_q <= TEST_UP;
            idx_q   <= '0;
            wcnt_q  <= '0;
          end
        end
        TEST_UP: begin
          if (wcnt_q == WCNT_LAST) begin
            hi_q    <= sync2_q[idx_q];
            wcnt_q  <= '0;
            state_q <= TEST_DN;
          end else begin
            wcnt_q  <= wcnt_q + WW'(1);
          end
        end
        TEST_DN: begin
          if (wcnt_q == WCNT_LAST) begin
            flt_q[idx_q] <= hi_q & ~sync2_q[idx_q];
            wcnt_q       <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= TEST_UP;
            end
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Conflicting pull requests cancel; the pad under test is overridden.
  always_comb begin
    pu_d = cfg_pu & ~cfg_pd;
    pd_d = cfg_pd & ~cfg_pu;
    if (state_q == TEST_UP) begin
      pu_d[idx_q] = 1'b1;
      pd_d[idx_q] = 1'b0;
    end else if (state_q == TEST_DN) begin
      pu_d[idx_q] = 1'b0;
      pd_d[idx_q] = 1'b1;
    end
  end

  // The scan deliberately wiggles pad values, so debounce is frozen while busy.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NPAD; i++) begin
      cnt_d[i] = '0;
      if (!busy && (sync2_q[i] != deb_q[i])) begin
        if (cnt_q[i] + DEBW'(1) == thr) begin
          deb_d[i] = sync2_q[i];
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + DEBW'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pu_q    <= '0;
      pd_q    <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_y;
      sync2_q <= sync1_q;
      pu_q    <= pu_d;
      pd_q    <= pd_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pad_pu     = pu_q;
  assign pad_pd     = pd_q;
  assign y_sync     = sync2_q;
  assign y_deb      = deb_q;
  assign scan_busy  = busy;
  assign scan_done  = (state_q == DONE);
  assign float_flag = flt_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io_in_ctrl.sv
// Directed bench for gf180mcu_ocd_io_in_ctrl with a floating/driven pad model.
module tb_gf180mcu_ocd_io_in_ctrl;

  localparam int NPAD   = 8;
  localparam int SETTLE = 6;
  localparam int DEBW   = 4;

  logic            CLK = 1'b0;
  logic            RN;
  logic [NPAD-1:0] cfg_pu, cfg_pd;
  logic [DEBW-1:0] deb_thresh;
  logic            scan_start;
  logic [NPAD-1:0] pad_y;
  logic [NPAD-1:0] pad_pu, pad_pd, y_sync, y_deb, float_flag;
  logic            scan_busy, scan_done;

  logic [NPAD-1:0] fmask, dval, drv;
  logic            use_model;

  int n_checks = 0;
  int n_fail   = 0;

  // Floating pads follow the applied pull-up; pulled-down or unpulled they read 0.
  assign pad_y = use_model ? ((dval & ~fmask) | (fmask & pad_pu)) : drv;

  gf180mcu_ocd_io_in_ctrl #(.NPAD(NPAD), .SETTLE(SETTLE), .DEBW(DEBW)) dut (
    .CLK(CLK), .RN(RN), .cfg_pu(cfg_pu), .cfg_pd(cfg_pd), .deb_thresh(deb_thresh),
    .scan_start(scan_start), .pad_y(pad_y), .pad_pu(pad_pu), .pad_pd(pad_pd),
    .y_sync(y_sync), .y_deb(y_deb), .scan_busy(scan_busy), .scan_done(scan_done),
    .float_flag(float_flag)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic run_scan(input bit poke, input int peek_k,
                          output int nbusy, output int ndone, output int done_k,
                          output int nperr, output logic [NPAD-1:0] peek_val);
    logic [NPAD-1:0] bpu, bpd, epu, epd, m;
    int k, j, p;
    bit up;
    nbusy = 0; ndone = 0; done_k = -1; nperr = 0; peek_val = '0;
    bpu = cfg_pu & ~cfg_pd;
    bpd = cfg_pd & ~cfg_pu;
    @(negedge CLK); scan_start = 1'b1;
    @(negedge CLK); scan_start = 1'b0;
    k = 0;
    while (scan_busy && k < 300) begin
      nbusy++;
      if (k == 0) begin
        epu = bpu; epd = bpd;
      end else begin
        j  = k - 1;
        p  = j / (2 * SETTLE);
        up = (j % (2 * SETTLE)) < SETTLE;
        m  = 8'h01 << p;
        epu = up ? (bpu | m) : (bpu & ~m);
        epd = up ? (bpd & ~m) : (bpd | m);
      end
      if (pad_pu !== epu || pad_pd !== epd) nperr++;
      if (k == peek_k) peek_val = float_flag;
      if (scan_done) begin
        ndone++;
        done_k = k;
        if (poke) scan_start = 1'b1;
      end else if (poke && k == 20) begin
        scan_start = 1'b1;
      end
      @(negedge CLK);
      scan_start = 1'b0;
      k++;
    end
  endtask

  int nbusy, ndone, done_k, nperr, idle_bad;
  logic [NPAD-1:0] peek;
  logic seen;

  initial begin
    RN = 1'b0; cfg_pu = '0; cfg_pd = '0; deb_thresh = 4'd3; scan_start = 1'b0;
    fmask = '0; dval = '0; drv = '0; use_model = 1'b0;
    #2;
    check_eq("reset_outs", {pad_pu, pad_pd, y_sync, y_deb, scan_busy, scan_done, float_flag}, 64'h0);
    wait_neg(2);
    RN = 1'b1;
    wait_neg(2);

    // Pull decode
    cfg_pu = 8'h0F; cfg_pd = 8'h3C;
    @(negedge CLK);
    check_eq("pull_pu", pad_pu, 8'h03);
    check_eq("pull_pd", pad_pd, 8'h30);
    check_eq("idle_busy", scan_busy, 1'b0);

    // Debounce, threshold 3
    cfg_pu = '0; cfg_pd = '0;
    wait_neg(4);
    drv[0] = 1'b1;
    @(negedge CLK); check_eq("sync_lag1", y_sync[0], 1'b0);
    @(negedge CLK); check_eq("sync_lag2", y_sync[0], 1'b1);
    wait_neg(2);    check_eq("deb_t_minus1", y_deb[0], 1'b0);
    @(negedge CLK); check_eq("deb_t", y_deb[0], 1'b1);
    drv[0] = 1'b0;
    wait_neg(8);    check_eq("deb_back0", y_deb[0], 1'b0);

    // Two-cycle glitch must not pass
    drv[0] = 1'b1;
    wait_neg(2);
    drv[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      seen = seen | y_deb[0];
    end
    check_eq("deb_glitch", seen, 1'b0);

    // Threshold 0 acts as 1
    deb_thresh = 4'd0;
    drv[1] = 1'b1;
    wait_neg(2);    check_eq("thr0_pre", y_deb[1], 1'b0);
    @(negedge CLK); check_eq("thr0_post", y_deb[1], 1'b1);
    drv[1] = 1'b0;
    deb_thresh = 4'd3;
    wait_neg(6);

    // Scan 1: pad 2 floats, stray start pulses mid-scan and in DONE
    use_model = 1'b1; fmask = 8'h04; dval = 8'h00;
    cfg_pu = 8'hA0; cfg_pd = 8'h05;
    wait_neg(4);
    run_scan(1'b1, -1, nbusy, ndone, done_k, nperr, peek);
    check_eq("s1_busy_len", nbusy, 97);
    check_eq("s1_done_cnt", ndone, 1);
    check_eq("s1_done_last", done_k, 96);
    check_eq("s1_pull_seq", nperr, 0);
    check_eq("s1_float", float_flag, 8'h04);
    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (scan_busy || scan_done) idle_bad++;
      @(negedge CLK);
    end
    check_eq("s1_idle_after", idle_bad, 0);

    // Scan 2: pad 2 driven high, old flag held until pad 2 is re-tested
    fmask = 8'h00; dval = 8'h04;
    wait_neg(4);
    run_scan(1'b0, 20, nbusy, ndone, done_k, nperr, peek);
    check_eq("s2_busy_len", nbusy, 97);
    check_eq("s2_done_cnt", ndone, 1);
    check_eq("s2_pull_seq", nperr, 0);
    check_eq("s2_flag_hold", peek, 8'h04);
    check_eq("s2_float", float_flag, 8'h00);

    // Scan 3: reset asserted at cycle 40
    fmask = 8'h04; dval = 8'h80;
    wait_neg(8);
    ndone = 0;
    @(negedge CLK); scan_start = 1'b1;
    @(negedge CLK); scan_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (scan_done) ndone++;
      @(negedge CLK);
    end
    check_eq("abort_busy_pre", scan_busy, 1'b1);
    check_eq("abort_flag_pre", float_flag, 8'h04);
    #2 RN = 1'b0;
    #1;
    check_eq("abort_outs", {pad_pu, pad_pd, y_sync, y_deb, scan_busy, scan_done, float_flag}, 64'h0);
    check_eq("abort_no_done", ndone, 0);
    wait_neg(2);
    RN = 1'b1;
    wait_neg(8);

    // Scan after release completes normally
    run_scan(1'b0, -1, nbusy, ndone, done_k, nperr, peek);
    check_eq("s4_busy_len", nbusy, 97);
    check_eq("s4_done_cnt", ndone, 1);
    check_eq("s4_pull_seq", nperr, 0);
    check_eq("s4_float", float_flag, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
